// File: rtl/sent_pkg.sv
// Shared constants for the SENT CRC engine: polynomials, seeds, channel kinds
// and the controller state encoding.
package sent_pkg;

  localparam logic [3:0] CRC4_POLY = 4'hD;
  localparam logic [3:0] CRC4_SEED = 4'h5;
  localparam logic [5:0] CRC6_POLY = 6'h19;
  localparam logic [5:0] CRC6_SEED = 6'h15;

  localparam logic CRC_KIND_FAST   = 1'b0;
  localparam logic CRC_KIND_SERIAL = 1'b1;

  // Enhanced serial: four 6-bit data symbols followed by one zero symbol
  localparam logic [3:0] CRC6_DATA_SYMS  = 4'd4;
  localparam logic [3:0] CRC6_TOTAL_SYMS = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sent_crc_sym.sv
// Combinational single-symbol CRC update, bitwise MSB-first.
// kind selects the 4-bit fast-channel or 6-bit serial polynomial.
module sent_crc_sym
  import sent_pkg::*;
(
  input  logic       kind,
  input  logic [5:0] crc_in,
  input  logic [5:0] sym,
  output logic [5:0] crc_out
);

  logic [5:0] c6;
  logic [3:0] c4;
  logic       fb;

  always_comb begin
    c6 = crc_in;
    c4 = crc_in[3:0];
    fb = 1'b0;
    if (kind == CRC_KIND_SERIAL) begin
      for (int i = 5; i >= 0; i--) begin
        fb = c6[5] ^ sym[i];
        c6 = {c6[4:0], 1'b0} ^ (fb ? CRC6_POLY : 6'h00);
      end
      crc_out = c6;
    end else begin
      for (int i = 3; i >= 0; i--) begin
        fb = c4[3] ^ sym[i];
        c4 = {c4[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'h0);
      end
      crc_out = {2'b00, c4};
    end
  end

endmodule

// File: rtl/sent_crc_engine.sv
// Time-multiplexed SENT CRC4/CRC6 calculator shared by NUM_CH channels,
// with round-robin arbitration and a received-CRC compare.
module sent_crc_engine
  import sent_pkg::*;
#(
  parameter  int NUM_CH  = 2,
  parameter  int MAX_NIB = 6,
  localparam int DATA_W  = 4 * MAX_NIB,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_kind,
  input  logic [NUM_CH-1:0]        ch_mode,
  input  logic [3*NUM_CH-1:0]      ch_len,
  input  logic [DATA_W*NUM_CH-1:0] ch_data,
  input  logic [6*NUM_CH-1:0]      ch_rx_crc,
  output logic                     crc_valid,
  output logic [CH_W-1:0]          crc_ch,
  output logic [5:0]               crc_out,
  output logic                     crc_err,
  output logic                     busy
);

  localparam logic [3:0] MAX_NIB_L = 4'((MAX_NIB > 15) ? 15 : MAX_NIB);

  state_e state_q, state_d;

  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              kind_q, kind_d;
  logic [5:0]        rx_q, rx_d;
  logic [3:0]        ndata_q, ndata_d;
  logic [3:0]        nsym_q, nsym_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [5:0]        crc_q, crc_d;
  logic [CH_W-1:0]   owner_q, owner_d;
  logic              valid_q, valid_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [5:0]        out_crc_q, out_crc_d;
  logic              out_err_q, out_err_d;

  logic              grant_en, calc_en, done_en;
  logic              gnt_found;
  logic [CH_W-1:0]   gnt_idx;
  logic [NUM_CH-1:0] gnt_onehot;
  int                ptr_int;

  logic [DATA_W-1:0] sel_data;
  logic              sel_kind, sel_mode;
  logic [5:0]        sel_rx;
  logic [3:0]        sel_len;
  logic [5:0]        sym_in, sym_crc;
  logic              last_sym;

  // Round-robin: scan channels starting just after the last grant
  always_comb begin
    gnt_found  = 1'b0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    ptr_int    = int'(rr_ptr_q);
    for (int k = 0; k < NUM_CH; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!gnt_found && (i == (ptr_int + 1 + k) % NUM_CH) && pending_q[i]) begin
          gnt_found     = 1'b1;
          gnt_idx       = CH_W'(i);
          gnt_onehot[i] = grant_en;
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_kind = 1'b0;
    sel_mode = 1'b0;
    sel_rx   = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == gnt_idx) begin
        sel_data = ch_data[i*DATA_W +: DATA_W];
        sel_kind = ch_kind[i];
        sel_mode = ch_mode[i];
        sel_rx   = ch_rx_crc[i*6 +: 6];
        sel_len  = {1'b0, ch_len[i*3 +: 3]};
      end
    end
    if (sel_len > MAX_NIB_L) begin
      sel_len = MAX_NIB_L;
    end
  end

  // Symbols past the data portion are the zero augmentation symbols
  always_comb begin
    sym_in = 6'h00;
    if (cnt_q < ndata_q) begin
      sym_in = (kind_q == CRC_KIND_SERIAL) ? shreg_q[DATA_W-1 -: 6]
                                           : {2'b00, shreg_q[DATA_W-1 -: 4]};
    end
  end

  assign last_sym = ((cnt_q + 4'd1) == nsym_q);

  sent_crc_sym u_sym (
    .kind    (kind_q),
    .crc_in  (crc_q),
    .sym     (sym_in),
    .crc_out (sym_crc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (gnt_found) state_d = ST_LOAD;
      ST_LOAD: state_d = (nsym_q == 4'd0) ? ST_DONE : ST_CALC;
      ST_CALC: if (last_sym) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_en = (state_q == ST_IDLE);
    calc_en  = (state_q == ST_CALC);
    done_en  = (state_q == ST_DONE);
    busy     = (state_q != ST_IDLE);
  end

  always_comb begin
    pending_d = (pending_q & ~gnt_onehot) | ch_req;
    rr_ptr_d  = rr_ptr_q;
    shreg_d   = shreg_q;
    kind_d    = kind_q;
    rx_d      = rx_q;
    ndata_d   = ndata_q;
    nsym_d    = nsym_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    owner_d   = owner_q;
    valid_d   = 1'b0;
    out_ch_d  = out_ch_q;
    out_crc_d = out_crc_q;
    out_err_d = out_err_q;

    if (grant_en && gnt_found) begin
      rr_ptr_d = gnt_idx;
      owner_d  = gnt_idx;
      shreg_d  = sel_data;
      kind_d   = sel_kind;
      rx_d     = sel_rx;
      cnt_d    = 4'd0;
      if (sel_kind == CRC_KIND_SERIAL) begin
        ndata_d = CRC6_DATA_SYMS;
        nsym_d  = CRC6_TOTAL_SYMS;
        crc_d   = CRC6_SEED;
      end else begin
        ndata_d = sel_len;
        nsym_d  = sel_len + {3'b000, sel_mode};
        crc_d   = {2'b00, CRC4_SEED};
      end
    end

    if (calc_en) begin
      crc_d   = sym_crc;
      shreg_d = (kind_q == CRC_KIND_SERIAL) ? (shreg_q << 6) : (shreg_q << 4);
      cnt_d   = cnt_q + 4'd1;
    end

    if (done_en) begin
      valid_d   = 1'b1;
      out_ch_d  = owner_q;
      out_crc_d = crc_q;
      out_err_d = (kind_q == CRC_KIND_SERIAL) ? (crc_q != rx_q)
                                              : (crc_q[3:0] != rx_q[3:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      rr_ptr_q  <= CH_W'(NUM_CH - 1);
      shreg_q   <= '0;
      kind_q    <= 1'b0;
      rx_q      <= '0;
      ndata_q   <= '0;
      nsym_q    <= '0;
      cnt_q     <= '0;
      crc_q     <= '0;
      owner_q   <= '0;
      valid_q   <= 1'b0;
      out_ch_q  <= '0;
      out_crc_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      shreg_q   <= shreg_d;
      kind_q    <= kind_d;
      rx_q      <= rx_d;
      ndata_q   <= ndata_d;
      nsym_q    <= nsym_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      owner_q   <= owner_d;
      valid_q   <= valid_d;
      out_ch_q  <= out_ch_d;
      out_crc_q <= out_crc_d;
      out_err_q <= out_err_d;
    end
  end

  assign crc_valid = valid_q;
  assign crc_ch    = out_ch_q;
  assign crc_out   = out_crc_q;
  assign crc_err   = out_err_q;

endmodule

// File: tb/tb_sent_crc_engine.sv
// Scoreboard bench for sent_crc_engine: stimulus pushes expected results,
// a negedge monitor pops and compares on every crc_valid.
module tb_sent_crc_engine;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 24;

  logic                     clk;
  logic                     rst;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_kind;
  logic [NUM_CH-1:0]        ch_mode;
  logic [3*NUM_CH-1:0]      ch_len;
  logic [DATA_W*NUM_CH-1:0] ch_data;
  logic [6*NUM_CH-1:0]      ch_rx_crc;
  logic                     crc_valid;
  logic [0:0]               crc_ch;
  logic [5:0]               crc_out;
  logic                     crc_err;
  logic                     busy;

  typedef struct {
    int ch;
    int crc;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  sent_crc_engine #(.NUM_CH(NUM_CH), .MAX_NIB(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_req    (ch_req),
    .ch_kind   (ch_kind),
    .ch_mode   (ch_mode),
    .ch_len    (ch_len),
    .ch_data   (ch_data),
    .ch_rx_crc (ch_rx_crc),
    .crc_valid (crc_valid),
    .crc_ch    (crc_ch),
    .crc_out   (crc_out),
    .crc_err   (crc_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Independent bitwise reference for both CRC kinds
  function automatic int crc_model(input int kind, input int mode, input int len,
                                   input logic [23:0] data);
    logic [5:0]  c;
    logic [29:0] b;
    logic [3:0]  c4;
    logic [3:0]  nib;
    logic        fb;
    int          n;
    if (kind != 0) begin
      c = 6'h15;
      b = {data, 6'b000000};
      for (int i = 29; i >= 0; i--) begin
        fb = c[5] ^ b[i];
        c  = {c[4:0], 1'b0} ^ (fb ? 6'h19 : 6'h00);
      end
      return 32'(c);
    end
    n  = (len > 6) ? 6 : len;
    c4 = 4'h5;
    for (int j = 0; j < n + mode; j++) begin
      nib = (j < n) ? data[23-4*j -: 4] : 4'h0;
      for (int i = 3; i >= 0; i--) begin
        fb = c4[3] ^ nib[i];
        c4 = {c4[2:0], 1'b0} ^ (fb ? 4'hD : 4'h0);
      end
    end
    return 32'(c4);
  endfunction

  task automatic push_exp(input int ch, input int crc, input int err);
    exp_t e;
    e.ch  = ch;
    e.crc = crc;
    e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic set_fields(input int ch, input int kind, input int mode, input int len,
                            input logic [23:0] data, input int rx);
    ch_kind[ch]             = kind[0];
    ch_mode[ch]             = mode[0];
    ch_len[3*ch +: 3]       = 3'(len);
    ch_data[DATA_W*ch +: DATA_W] = data;
    ch_rx_crc[6*ch +: 6]    = 6'(rx);
  endtask

  // Called at a negedge: one-cycle request pulse, returns at the next negedge
  task automatic apply_stimulus(input int ch, input int kind, input int mode, input int len,
                                input logic [23:0] data, input int rx);
    set_fields(ch, kind, mode, len, data, rx);
    ch_req[ch] = 1'b1;
    @(negedge clk);
    ch_req[ch] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int done;
    done = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !busy) begin
        done = 1;
        break;
      end
    end
    check_output({"drain_", name}, done, 1);
    repeat (12) @(negedge clk);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && crc_valid) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_output("crc_ch", int'(crc_ch), e.ch);
        check_output("crc_out", int'(crc_out), e.crc);
        check_output("crc_err", int'(crc_err), e.err);
      end
    end
  end

  initial begin
    int kind, mode, len, rx, crc, ch;
    logic [23:0] data;

    rst       = 1'b1;
    ch_req    = '0;
    ch_kind   = '0;
    ch_mode   = '0;
    ch_len    = '0;
    ch_data   = '0;
    ch_rx_crc = '0;
    repeat (3) @(negedge clk);
    check_output("rst_valid", int'(crc_valid), 0);
    check_output("rst_out", int'(crc_out), 0);
    check_output("rst_ch", int'(crc_ch), 0);
    check_output("rst_err", int'(crc_err), 0);
    check_output("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] CRC4 legacy single zero nibble, latency");
    set_fields(0, 0, 0, 1, 24'h0, 6'h03);
    push_exp(0, 'h3, 0);
    ch_req[0] = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk);
      #1;
      ch_req[0] = 1'b0;
      check_output($sformatf("latency_edge%0d", k), int'(crc_valid), (k == 4) ? 1 : 0);
    end
    wait_idle("t1");

    $display("[TB] CRC4 recommended and rx compare");
    apply_stimulus(0, 0, 1, 1, 24'h0, 'h0A);
    push_exp(0, 'hA, 0);
    wait_idle("t2a");
    apply_stimulus(0, 0, 1, 1, 24'h0, 'h03);
    push_exp(0, 'hA, 1);
    wait_idle("t2b");
    apply_stimulus(0, 0, 1, 1, 24'h0, 'h3A);
    push_exp(0, 'hA, 0);
    wait_idle("t2c");

    $display("[TB] CRC6 zero data and random vectors");
    apply_stimulus(0, 1, 0, 0, 24'h0, 'h26);
    push_exp(0, 'h26, 0);
    wait_idle("t3a");
    apply_stimulus(1, 1, 0, 0, 24'h0, 'h06);
    push_exp(1, 'h26, 1);
    wait_idle("t3b");
    for (int i = 0; i < 8; i++) begin
      ch   = i % 2;
      kind = int'($urandom_range(1, 0));
      mode = int'($urandom_range(1, 0));
      len  = int'($urandom_range(7, 0));
      data = 24'($urandom());
      crc  = crc_model(kind, mode, len, data);
      rx   = (i % 3 == 0) ? int'($urandom_range(63, 0)) : crc;
      apply_stimulus(ch, kind, mode, len, data, rx);
      push_exp(ch, crc, (kind != 0) ? int'(crc != rx) : int'((crc & 15) != (rx & 15)));
      wait_idle($sformatf("rand%0d", i));
    end

    $display("[TB] length clamp and zero length");
    apply_stimulus(0, 0, 0, 6, 24'h123456, 0);
    push_exp(0, crc_model(0, 0, 6, 24'h123456), int'(crc_model(0, 0, 6, 24'h123456) != 0));
    wait_idle("t6a");
    apply_stimulus(0, 0, 0, 7, 24'h123456, 0);
    push_exp(0, crc_model(0, 0, 6, 24'h123456), int'(crc_model(0, 0, 6, 24'h123456) != 0));
    wait_idle("t6b");
    apply_stimulus(1, 0, 0, 0, 24'hFFFFFF, 'h05);
    push_exp(1, 'h5, 0);
    wait_idle("t6c");
    apply_stimulus(1, 0, 1, 0, 24'hFFFFFF, 'h05);
    push_exp(1, 'h3, 1);
    wait_idle("t6d");

    $display("[TB] arbitration");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_fields(0, 0, 0, 1, 24'h0, 'h3);
    set_fields(1, 0, 0, 0, 24'h0, 'h5);
    ch_req = 2'b11;
    push_exp(0, 'h3, 0);
    push_exp(1, 'h5, 0);
    @(negedge clk);
    ch_req = 2'b00;
    wait_idle("t4a");

    for (int i = 0; i < 6; i++) push_exp(i % 2, (i % 2 == 0) ? 'h3 : 'h5, 0);
    ch_req = 2'b11;
    begin
      int seen;
      seen = 0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        #1;
        if (exp_q.size() == 2) begin
          seen = 1;
          break;
        end
      end
      ch_req = 2'b00;
      check_output("continuous_progress", seen, 1);
    end
    wait_idle("t4b");

    apply_stimulus(1, 1, 0, 0, 24'h0, 'h26);
    push_exp(1, 'h26, 0);
    push_exp(0, 'h3, 0);
    set_fields(0, 0, 0, 1, 24'h0, 'h3);
    ch_req[0] = 1'b1;
    @(negedge clk);
    ch_req[0] = 1'b0;
    @(negedge clk);
    ch_req[0] = 1'b1;
    @(negedge clk);
    ch_req[0] = 1'b0;
    wait_idle("t4c");

    $display("[TB] reset during calculation");
    apply_stimulus(0, 1, 0, 0, 24'hABCDEF, 0);
    apply_stimulus(1, 0, 0, 2, 24'h550000, 0);
    @(negedge clk);
    check_output("busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    #1;
    check_output("abort_valid", int'(crc_valid), 0);
    check_output("abort_out", int'(crc_out), 0);
    check_output("abort_ch", int'(crc_ch), 0);
    check_output("abort_err", int'(crc_err), 0);
    check_output("abort_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_output("pending_cleared", int'(busy), 0);
    apply_stimulus(1, 0, 1, 1, 24'h0, 'hA);
    push_exp(1, 'hA, 0);
    wait_idle("t5");

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
